// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES frame scheduler: ingress FSM states,
// tag width helper and the port-count ceiling.
package aes_sched_pkg;

    localparam int MAX_PORTS = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ingress_state_e;

    function automatic int id_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/aes_tag_fifo.sv
// First-word-fall-through FIFO holding the source port of every frame admitted
// into the engine, in admission order. DEPTH must be a power of two, >= 2.
module aes_tag_fifo
    import aes_sched_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aes_frame_scheduler.sv
// Frame-granular round-robin sharing of one AES engine between NUM_PORTS
// AXI-Stream requesters; results are steered back by an in-order source tag.
module aes_frame_scheduler
    import aes_sched_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int DATA_WIDTH      = 512,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 16,
    parameter int ID_WIDTH        = id_width(NUM_PORTS)
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0][KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]                 s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                 s_axis_tready,
    input  logic [NUM_PORTS-1:0]                 s_axis_tlast,

    output logic [DATA_WIDTH-1:0]                m_eng_tdata,
    output logic [KEEP_WIDTH-1:0]                m_eng_tkeep,
    output logic                                 m_eng_tvalid,
    input  logic                                 m_eng_tready,
    output logic                                 m_eng_tlast,

    input  logic [DATA_WIDTH-1:0]                s_eng_tdata,
    input  logic [KEEP_WIDTH-1:0]                s_eng_tkeep,
    input  logic                                 s_eng_tvalid,
    output logic                                 s_eng_tready,
    input  logic                                 s_eng_tlast,

    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] m_axis_tdata,
    output logic [NUM_PORTS-1:0][KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [NUM_PORTS-1:0]                 m_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                 m_axis_tready,
    output logic [NUM_PORTS-1:0]                 m_axis_tlast,

    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                 err_orphan
);

    ingress_state_e      state;
    logic [ID_WIDTH-1:0] grant;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] scan_idx;
    logic [ID_WIDTH-1:0] scan_sel;
    logic                scan_hit;
    logic                admit;
    logic                eng_beat;

    logic [ID_WIDTH-1:0] tag_head;
    logic                tag_empty;
    logic                tag_full;
    logic                tag_pop;

    // Walk the ring backwards so the valid port closest to rr_ptr wins.
    always_comb begin
        scan_hit = 1'b0;
        scan_sel = '0;
        scan_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            scan_idx = ID_WIDTH'((int'(rr_ptr) + i) % NUM_PORTS);
            if (s_axis_tvalid[scan_idx]) begin
                scan_hit = 1'b1;
                scan_sel = scan_idx;
            end
        end
    end

    assign admit    = (state == IDLE) && scan_hit && !tag_full;
    assign eng_beat = (state == STREAM) && s_axis_tvalid[grant] && m_eng_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else if (admit) begin
            state <= STREAM;
            grant <= scan_sel;
        end else if (eng_beat && s_axis_tlast[grant]) begin
            state  <= IDLE;
            rr_ptr <= (grant == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant + ID_WIDTH'(1);
        end
    end

    assign m_eng_tdata  = s_axis_tdata[grant];
    assign m_eng_tkeep  = s_axis_tkeep[grant];
    assign m_eng_tlast  = s_axis_tlast[grant];
    assign m_eng_tvalid = (state == STREAM) && s_axis_tvalid[grant];

    always_comb begin
        s_axis_tready = '0;
        if (state == STREAM) begin
            s_axis_tready[grant] = m_eng_tready;
        end
    end

    // The tag is pushed at admission, so a result can never outrun its tag.
    aes_tag_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (admit),
        .din   (scan_sel),
        .pop   (tag_pop),
        .head  (tag_head),
        .empty (tag_empty),
        .full  (tag_full),
        .count (outstanding)
    );

    assign m_axis_tdata = {NUM_PORTS{s_eng_tdata}};
    assign m_axis_tkeep = {NUM_PORTS{s_eng_tkeep}};
    assign m_axis_tlast = {NUM_PORTS{s_eng_tlast}};

    // With no tag outstanding, engine output has no owner and is drained.
    always_comb begin
        m_axis_tvalid = '0;
        s_eng_tready  = 1'b1;
        if (!tag_empty) begin
            m_axis_tvalid[tag_head] = s_eng_tvalid;
            s_eng_tready            = m_axis_tready[tag_head];
        end
    end

    assign tag_pop = !tag_empty && s_eng_tvalid && s_eng_tready && s_eng_tlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_orphan <= 1'b0;
        end else if (tag_empty && s_eng_tvalid) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_frame_scheduler.sv
// Directed-random bench: per-port source queues, an 8-cycle delay engine and
// per-port expected-result queues; grant order comes from a round-robin model.
module tb_aes_frame_scheduler;

    localparam int NP      = 4;
    localparam int DW      = 32;
    localparam int KW      = DW / 8;
    localparam int MO      = 16;
    localparam int CW      = $clog2(MO) + 1;
    localparam int ENG_LAT = 8;
    localparam logic [DW-1:0] KEY = 32'h5A3C_96E1;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        int            due;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NP-1:0][DW-1:0] s_axis_tdata  = '0;
    logic [NP-1:0][KW-1:0] s_axis_tkeep  = '0;
    logic [NP-1:0]         s_axis_tvalid = '0;
    logic [NP-1:0]         s_axis_tready;
    logic [NP-1:0]         s_axis_tlast  = '0;
    logic [DW-1:0]         m_eng_tdata;
    logic [KW-1:0]         m_eng_tkeep;
    logic                  m_eng_tvalid;
    logic                  m_eng_tready  = 1'b1;
    logic                  m_eng_tlast;
    logic [DW-1:0]         s_eng_tdata   = '0;
    logic [KW-1:0]         s_eng_tkeep   = '0;
    logic                  s_eng_tvalid  = 1'b0;
    logic                  s_eng_tready;
    logic                  s_eng_tlast   = 1'b0;
    logic [NP-1:0][DW-1:0] m_axis_tdata;
    logic [NP-1:0][KW-1:0] m_axis_tkeep;
    logic [NP-1:0]         m_axis_tvalid;
    logic [NP-1:0]         m_axis_tready = '1;
    logic [NP-1:0]         m_axis_tlast;
    logic [CW-1:0]         outstanding;
    logic                  err_orphan;

    aes_frame_scheduler #(
        .NUM_PORTS       (NP),
        .DATA_WIDTH      (DW),
        .KEEP_WIDTH      (KW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_eng_tdata   (m_eng_tdata),
        .m_eng_tkeep   (m_eng_tkeep),
        .m_eng_tvalid  (m_eng_tvalid),
        .m_eng_tready  (m_eng_tready),
        .m_eng_tlast   (m_eng_tlast),
        .s_eng_tdata   (s_eng_tdata),
        .s_eng_tkeep   (s_eng_tkeep),
        .s_eng_tvalid  (s_eng_tvalid),
        .s_eng_tready  (s_eng_tready),
        .s_eng_tlast   (s_eng_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .outstanding   (outstanding),
        .err_orphan    (err_orphan)
    );

    always #5 clk = ~clk;

    int      tests = 0;
    int      fails = 0;
    int      cyc   = 0;
    int      eng_budget = 1000000;
    beat_t   src_q [NP][$];
    beat_t   exp_q [NP][$];
    beat_t   eng_q [$];
    int      gl [$];
    int      gc [$];
    int      exp_gl [$];
    int      pend [NP];
    logic [NP-1:0] mid = '0;
    beat_t   nb;
    beat_t   rb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Posedge monitor: records admissions, scores results, runs the engine FIFO.
    always @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                if (s_axis_tvalid[p] && s_axis_tready[p] && src_q[p].size() > 0) begin
                    if (!mid[p]) begin
                        gl.push_back(p);
                        gc.push_back(cyc);
                    end
                    mid[p] = !s_axis_tlast[p];
                    void'(src_q[p].pop_front());
                end
                if (m_axis_tvalid[p] && m_axis_tready[p]) begin
                    chk($sformatf("port %0d result expected", p), (exp_q[p].size() > 0), 1);
                    if (exp_q[p].size() > 0) begin
                        rb = exp_q[p].pop_front();
                        chk($sformatf("port %0d data", p), m_axis_tdata[p], rb.data);
                        chk($sformatf("port %0d keep", p), m_axis_tkeep[p], rb.keep);
                        chk($sformatf("port %0d last", p), m_axis_tlast[p], rb.last);
                    end
                end
            end
            if (m_eng_tvalid && m_eng_tready) begin
                nb.data = m_eng_tdata ^ KEY;
                nb.keep = m_eng_tkeep;
                nb.last = m_eng_tlast;
                nb.due  = cyc + ENG_LAT;
                eng_q.push_back(nb);
            end
            if (s_eng_tvalid && s_eng_tready && eng_q.size() > 0) begin
                if (eng_q[0].last && eng_budget > 0) eng_budget--;
                void'(eng_q.pop_front());
            end
        end
        cyc++;
    end

    // Negedge drivers for requesters and the engine output.
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0) begin
                s_axis_tvalid[p] = 1'b1;
                s_axis_tdata[p]  = src_q[p][0].data;
                s_axis_tkeep[p]  = src_q[p][0].keep;
                s_axis_tlast[p]  = src_q[p][0].last;
            end else begin
                s_axis_tvalid[p] = 1'b0;
                s_axis_tdata[p]  = '0;
                s_axis_tkeep[p]  = '0;
                s_axis_tlast[p]  = 1'b0;
            end
        end
        if (!rst && eng_budget > 0 && eng_q.size() > 0 && eng_q[0].due <= cyc) begin
            s_eng_tvalid = 1'b1;
            s_eng_tdata  = eng_q[0].data;
            s_eng_tkeep  = eng_q[0].keep;
            s_eng_tlast  = eng_q[0].last;
        end else begin
            s_eng_tvalid = 1'b0;
            s_eng_tdata  = '0;
            s_eng_tkeep  = '0;
            s_eng_tlast  = 1'b0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_frame(input int p, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.keep = (i == len - 1) ? KW'($urandom_range(1, (1 << KW) - 1)) : '1;
            b.last = (i == len - 1);
            b.due  = 0;
            src_q[p].push_back(b);
            b.data = b.data ^ KEY;
            exp_q[p].push_back(b);
        end
    endtask

    function automatic int pending();
        int s = eng_q.size();
        for (int p = 0; p < NP; p++) s += src_q[p].size() + exp_q[p].size();
        return s;
    endfunction

    task automatic clear_model();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
        eng_q.delete();
        gl.delete();
        gc.delete();
        mid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        cycles(2);
        rst = 1'b0;
        step();
    endtask

    task automatic drain(input string tag, input int limit);
        int n = 0;
        while ((pending() != 0 || outstanding != '0) && n < limit) begin
            step();
            n++;
        end
        chk({tag, " drained in budget"}, (n < limit), 1);
        chk({tag, " outstanding idle"}, outstanding, 0);
    endtask

    // Round robin over frames queued up front: next grant is the first port
    // with frames left, searching from the port after the previous grant.
    task automatic rr_model(input int start);
        int ptr, left, q, g;
        logic hit;
        ptr = start;
        left = 0;
        exp_gl.delete();
        for (int p = 0; p < NP; p++) left += pend[p];
        while (left > 0) begin
            hit = 1'b0;
            g = 0;
            for (int k = 0; k < NP; k++) begin
                q = (ptr + k) % NP;
                if (!hit && pend[q] > 0) begin
                    hit = 1'b1;
                    g = q;
                end
            end
            exp_gl.push_back(g);
            pend[g]--;
            left--;
            ptr = (g + 1) % NP;
        end
    endtask

    task automatic check_grants(input string tag);
        chk({tag, " grant count"}, gl.size(), exp_gl.size());
        for (int i = 0; i < gl.size() && i < exp_gl.size(); i++)
            chk($sformatf("%s grant %0d", tag, i), gl[i], exp_gl[i]);
    endtask

    initial begin
        int n0, n2, k;

        // Reset state
        cycles(2);
        chk("rst m_eng_tvalid", m_eng_tvalid, 0);
        chk("rst s_axis_tready", s_axis_tready, 0);
        chk("rst m_axis_tvalid", m_axis_tvalid, 0);
        chk("rst s_eng_tready", s_eng_tready, 1);
        chk("rst outstanding", outstanding, 0);
        chk("rst err_orphan", err_orphan, 0);
        rst = 1'b0;
        step();

        // Ports 0 and 2 with back-to-back 3-beat frames
        n0 = $urandom_range(2, 3);
        n2 = $urandom_range(2, 3);
        for (int i = 0; i < n0; i++) load_frame(0, 3);
        for (int i = 0; i < n2; i++) load_frame(2, 3);
        pend = '{n0, 0, n2, 0};
        rr_model(0);
        drain("t1", 600);
        check_grants("t1");

        // All ports, single-beat frames: one arbitration cycle per frame
        do_reset();
        load_frame(0, 1);
        load_frame(0, 1);
        for (int p = 1; p < NP; p++) load_frame(p, 1);
        pend = '{2, 1, 1, 1};
        rr_model(0);
        drain("t2", 300);
        check_grants("t2");
        for (int i = 1; i < gc.size(); i++)
            chk($sformatf("t2 admit spacing %0d", i), gc[i] - gc[i-1], 2);

        // Engine output stalled: admission stops at the outstanding limit
        do_reset();
        eng_budget = 0;
        for (int i = 0; i < 18; i++) load_frame(1, $urandom_range(1, 3));
        cycles(120);
        chk("t3 admitted at limit", gl.size(), MO);
        chk("t3 outstanding at limit", outstanding, MO);
        chk("t3 port1 tready blocked", s_axis_tready[1], 0);
        eng_budget = 1;
        cycles(40);
        chk("t3 one more admitted", gl.size(), MO + 1);
        chk("t3 outstanding refilled", outstanding, MO);
        eng_budget = 1000000;
        drain("t3", 800);
        chk("t3 all admitted", gl.size(), 18);

        // Head-of-line: port 3 result blocked, port 1 result queued behind it
        do_reset();
        m_axis_tready = 4'b0111;
        load_frame(3, 2);
        cycles(4);
        load_frame(1, 2);
        cycles(20);
        chk("t4 s_eng_tready held", s_eng_tready, 0);
        chk("t4 only port3 valid", m_axis_tvalid, 4'b1000);
        chk("t4 outstanding two", outstanding, 2);
        load_frame(0, 1);
        cycles(8);
        chk("t4 ingress continues", outstanding, 3);
        exp_gl = {3, 1, 0};
        check_grants("t4");
        m_axis_tready = '1;
        drain("t4", 200);

        // Orphan beat with the tag FIFO empty
        do_reset();
        nb.data = $urandom;
        nb.keep = '1;
        nb.last = 1'b1;
        nb.due  = 0;
        eng_q.push_back(nb);
        cycles(3);
        chk("t5 orphan dropped", eng_q.size(), 0);
        chk("t5 err_orphan set", err_orphan, 1);
        cycles(5);
        chk("t5 err_orphan sticky", err_orphan, 1);
        do_reset();
        chk("t5 err_orphan cleared", err_orphan, 0);

        // Reset mid-frame, then round robin restarts from port 0
        load_frame(2, 1);
        load_frame(2, 6);
        k = 0;
        while (gl.size() < 2 && k < 50) begin
            step();
            k++;
        end
        chk("t6 second frame started", (gl.size() >= 2), 1);
        chk("t6 streaming before reset", m_eng_tvalid, 1);
        rst = 1'b1;
        #1;
        chk("t6 rst m_eng_tvalid", m_eng_tvalid, 0);
        chk("t6 rst s_axis_tready", s_axis_tready, 0);
        chk("t6 rst m_axis_tvalid", m_axis_tvalid, 0);
        chk("t6 rst s_eng_tready", s_eng_tready, 1);
        chk("t6 rst outstanding", outstanding, 0);
        clear_model();
        cycles(2);
        rst = 1'b0;
        step();
        load_frame(3, 1);
        load_frame(1, 1);
        pend = '{0, 1, 0, 1};
        rr_model(0);
        drain("t6", 200);
        check_grants("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_frame_scheduler.md
# aes_frame_scheduler

Shares one AES_engine instance between NUM_PORTS AXI-Stream requesters at frame granularity. Round-robin arbitration admits whole frames into the engine and records each frame's source ID in an in-order tag FIFO. Engine output frames are steered back to the originating port, which relies on the engine preserving frame order. The block sits between the per-flow packet pipelines and the AES datapath.

## Interface

Parameters:
- NUM_PORTS, 4 — number of requesters, 2..8
- DATA_WIDTH, 512 — stream width, matches the engine
- KEEP_WIDTH, DATA_WIDTH/8 — tkeep width
- MAX_OUTSTANDING, 16 — frames in flight in the engine; also the tag FIFO depth, a power of two
- ID_WIDTH, $clog2(NUM_PORTS) — width of the source tag

Ports (the s_axis_* and m_axis_* port buses are packed per-port vectors, with port i occupying slice i):
- clk  in  1  — single clock
- rst  in  1  — asynchronous, active-high reset
- s_axis_tdata/tkeep/tvalid/tready/tlast  in/in/in/out/in  NUM_PORTS×{DATA_WIDTH, KEEP_WIDTH, 1, 1, 1}  — requester inputs
- m_eng_tdata/tkeep/tvalid/tready/tlast  out/out/out/in/out  DATA_WIDTH/KEEP_WIDTH/1/1/1  — to engine s_axis
- s_eng_tdata/tkeep/tvalid/tready/tlast  in/in/in/out/in  DATA_WIDTH/KEEP_WIDTH/1/1/1  — from engine m_axis
- m_axis_tdata/tkeep/tvalid/tready/tlast  out/out/out/in/out  NUM_PORTS×{DATA_WIDTH, KEEP_WIDTH, 1, 1, 1}  — per-port results
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  — frames admitted but not yet returned
- err_orphan  out  1  — sticky; set when engine data arrives while the tag FIFO is empty

## Operation

Ingress FSM states:
- IDLE
  - Scan s_axis_tvalid starting from rr_ptr, wrapping modulo NUM_PORTS.
  - If any port is valid and outstanding < MAX_OUTSTANDING: latch grant = first valid port, push grant into the tag FIFO, go to STREAM.
  - Otherwise stay in IDLE. All s_axis_tready = 0.
- STREAM
  - m_eng_* = s_axis_*[grant].
  - s_axis_tready[grant] = m_eng_tready; all other s_axis_tready = 0.
  - On an accepted beat with tlast: rr_ptr <= (grant+1) mod NUM_PORTS, go to IDLE.

Counting:
- outstanding increments on a tag push and decrements on a tag pop.
- A push and a pop in the same cycle leave it unchanged.
- It never exceeds MAX_OUTSTANDING, because admission is blocked at the limit.

Egress, combinational steering:
- When the tag FIFO is non-empty, dest = tag head. m_axis_*[dest] = s_eng_*, s_eng_tready = m_axis_tready[dest]. All other m_axis_tvalid = 0.
- On an accepted s_eng beat with tlast, the tag FIFO pops.
- When the tag FIFO is empty, s_eng_tready = 1 (beats are drained and dropped). If s_eng_tvalid = 1, err_orphan is set and stays set until reset.

Other rules:
- A port's tvalid may drop mid-frame; the grant is held until tlast. No frame interleaving on either side.

## Timing

- Reset values:
  - FSM = IDLE, rr_ptr = 0, tag FIFO empty, outstanding = 0, err_orphan = 0.
  - All m_axis_tvalid = 0, m_eng_tvalid = 0, all s_axis_tready = 0.
  - s_eng_tready = 1, because the tag FIFO is empty.
- Arbitration costs exactly one IDLE cycle per frame. The first beat can pass at cycle N+1 after tvalid is seen in IDLE at cycle N.
- Beat latency is 0 cycles through both muxes: no registers on the data path.
- A single-beat frame occupies one IDLE cycle plus one STREAM cycle.
- Tag push happens on the IDLE→STREAM edge. A frame that returns before its ingress tail has completed is routed correctly, because the tag is already present.
- Asynchronous reset mid-frame abandons all partial frames. The engine and all neighbours share rst.

## Structure

- Package aes_sched_pkg:
  - ingress state enum {IDLE, STREAM}
  - the ID_WIDTH helper function
  - the MAX_PORTS = 8 constant
- Sub-module aes_tag_fifo:
  - synchronous FIFO of ID_WIDTH × MAX_OUTSTANDING, with push, pop, head, empty, full and count
  - first-word fall-through, with asynchronous reset

## Test plan

- Ports 0 and 2 each hold a 3-beat frame continuously, with the engine modelled as an 8-cycle delay FIFO → grants alternate 0,2,0,2; each result frame appears only on its source port, and outstanding returns to 0.
- All 4 ports valid, 1-beat frames → grant order 0,1,2,3,0; one idle cycle between admissions.
- Engine output stalled, port 1 streaming → exactly 16 frames admitted, then s_axis_tready[1] = 0 and outstanding = 16. Releasing one result frame re-enables one admission.
- m_axis_tready[3] = 0 while port 3's result is at the head → s_eng_tready = 0, and a port 1 result queued behind it waits (in-order). Ingress continues while outstanding < 16.
- s_eng_tvalid pulsed with an empty tag FIFO → beat dropped, err_orphan = 1 and it stays 1; reset clears it.
- rst asserted in STREAM mid-frame → same cycle: all tvalid/tready outputs drop to their reset values, outstanding = 0, rr_ptr = 0.
